// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl
//   Reset and lock supervisor for the system PLL, running from the board
//   reference clock. It sends a timed reset pulse to the PLL, watches the
//   synchronized PLL lock, and releases the core reset only after lock has
//   been stable for a programmable number of cycles. Lock loss in RUN, or no
//   lock within the timeout window, restarts the PLL reset sequence.
//
// Ports
//   refclk       in   reference clock (the only clock)
//   rst          in   synchronous active-high reset
//   pll_locked   in   raw PLL lock, asynchronous to refclk
//   pll_rst      out  reset to the PLL, active-high, registered
//   sys_reset    out  reset to the core clock domains, active-high, registered
//   ready        out  high while the supervisor is in RUN, registered
//   relock_count out  lock losses seen in RUN, saturates at 255
//   timeout_err  out  sticky lock-timeout flag, cleared only by rst
//
// All parameters must be >= 2, and CNT_W must hold the largest of them - 1.

module pll_reset_ctrl #(
  parameter int PLL_RST_CYCLES      = 50,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int CNT_W               = 20
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic [7:0] relock_count,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lk_s1_q, lk_s1_d;
  logic             lk_s2_q, lk_s2_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_reset_q, sys_reset_d;
  logic             ready_q, ready_d;
  logic [7:0]       relock_count_q, relock_count_d;
  logic             timeout_err_q, timeout_err_d;

  // Synchronizer stage: pll_locked -> lk_s1 -> lk_s2
  always_comb begin
    lk_s1_d = pll_locked;
    lk_s2_d = lk_s1_q;
  end

  // Sequencer stage: next state, shared counter, status, output decode
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    relock_count_d = relock_count_q;
    timeout_err_d  = timeout_err_q;

    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PLL_RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT_LOCK: begin
        // Lock arriving on the timeout cycle wins over the timeout.
        if (lk_s2_q) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = S_PLL_RST;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STABLE: begin
        // Lock loss wins over a completing stable count.
        if (!lk_s2_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RUN: begin
        if (!lk_s2_q) begin
          state_d = S_PLL_RST;
          cnt_d   = '0;
          if (relock_count_q != 8'hFF) begin
            relock_count_d = relock_count_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = S_PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // Decoding from the next state keeps outputs aligned with the transition edge.
    pll_rst_d   = (state_d == S_PLL_RST);
    sys_reset_d = (state_d != S_RUN);
    ready_d     = (state_d == S_RUN);
  end

  // Register stage
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q        <= S_PLL_RST;
      cnt_q          <= '0;
      lk_s1_q        <= 1'b0;
      lk_s2_q        <= 1'b0;
      pll_rst_q      <= 1'b1;
      sys_reset_q    <= 1'b1;
      ready_q        <= 1'b0;
      relock_count_q <= 8'd0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      lk_s1_q        <= lk_s1_d;
      lk_s2_q        <= lk_s2_d;
      pll_rst_q      <= pll_rst_d;
      sys_reset_q    <= sys_reset_d;
      ready_q        <= ready_d;
      relock_count_q <= relock_count_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign sys_reset    = sys_reset_q;
  assign ready        = ready_q;
  assign relock_count = relock_count_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Testbench for pll_reset_ctrl with short sequencing parameters.
// A timestamp-based reference model predicts every output on every edge;
// directed scenarios add explicit latency and boundary checks.

module tb_pll_reset_ctrl;

  localparam int P = 4;
  localparam int L = 8;
  localparam int T = 32;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic [7:0] relock_count;
  logic       timeout_err;

  pll_reset_ctrl #(
    .PLL_RST_CYCLES      (P),
    .LOCK_STABLE_CYCLES  (L),
    .LOCK_TIMEOUT_CYCLES (T),
    .CNT_W               (8)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .sys_reset    (sys_reset),
    .ready        (ready),
    .relock_count (relock_count),
    .timeout_err  (timeout_err)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  int n_checks;
  int n_fail;
  int cnt;

  // Reference model: phase 0=PLL reset, 1=wait lock, 2=stable, 3=run.
  // t0 is the edge number on which the current phase was entered.
  int n_edge;
  int last_rst;
  int ph;
  int t0;
  int m_relock;
  bit m_terr;
  bit samp [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit l;
    int el;
    n_edge++;
    if (rst) begin
      ph       = 0;
      t0       = n_edge;
      m_relock = 0;
      m_terr   = 1'b0;
      last_rst = n_edge;
    end else begin
      // Decisions see the input value sampled two edges earlier,
      // or 0 while the synchronizer is still flushing after reset.
      l  = (n_edge - 2 > last_rst) ? samp[(n_edge - 2) % 4] : 1'b0;
      el = n_edge - t0;
      case (ph)
        0: if (el == P) begin ph = 1; t0 = n_edge; end
        1: begin
          if (l) begin ph = 2; t0 = n_edge; end
          else if (el == T) begin ph = 0; t0 = n_edge; m_terr = 1'b1; end
        end
        2: begin
          if (!l) begin ph = 1; t0 = n_edge; end
          else if (el == L) begin ph = 3; t0 = n_edge; end
        end
        default: begin
          if (!l) begin
            ph = 0;
            t0 = n_edge;
            if (m_relock < 255) m_relock++;
          end
        end
      endcase
    end
    samp[n_edge % 4] = pll_locked;
  endtask

  task automatic step();
    @(posedge refclk);
    model_edge();
    #1;
    chk("m_pll_rst",   32'(pll_rst),      32'(ph == 0));
    chk("m_sys_reset", 32'(sys_reset),    32'(ph != 3));
    chk("m_ready",     32'(ready),        32'(ph == 3));
    chk("m_relock",    32'(relock_count), m_relock);
    chk("m_terr",      32'(timeout_err),  32'(m_terr));
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_fail = 0; n_edge = 0; last_rst = 0;
    ph = 0; t0 = 0; m_relock = 0; m_terr = 1'b0;
    for (int i = 0; i < 4; i++) samp[i] = 1'b0;

    // Reset held for 3 cycles
    rst = 1'b1; pll_locked = 1'b0;
    repeat (3) step();
    chk("rst_pll_rst",   32'(pll_rst), 1);
    chk("rst_sys_reset", 32'(sys_reset), 1);
    chk("rst_ready",     32'(ready), 0);
    chk("rst_relock",    32'(relock_count), 0);
    chk("rst_terr",      32'(timeout_err), 0);

    // Power-on: PLL reset pulse length, then lock-to-ready latency
    rst = 1'b0;
    cnt = 0;
    while (pll_rst === 1'b1 && cnt < 20) begin step(); cnt++; end
    chk("por_pulse_len", cnt, P);
    repeat (10 - P) step();
    pll_locked = 1'b1;
    cnt = 0;
    do begin step(); cnt++; end while (ready !== 1'b1 && cnt < 50);
    chk("lock_to_ready", cnt - 1, L + 2);
    chk("por_sys_reset", 32'(sys_reset), 0);
    chk("por_relock", 32'(relock_count), 0);

    // Three lock losses in RUN, re-locking each time
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 5)) step();
      pll_locked = 1'b0;
      step();
      chk("loss_k0_sys_reset", 32'(sys_reset), 0);
      step();
      chk("loss_k1_sys_reset", 32'(sys_reset), 0);
      step();
      chk("loss_k2_sys_reset", 32'(sys_reset), 1);
      chk("loss_k2_pll_rst",   32'(pll_rst), 1);
      chk("loss_k2_ready",     32'(ready), 0);
      chk("loss_k2_relock",    32'(relock_count), i + 1);
      pll_locked = 1'b1;
      cnt = 0;
      do begin step(); cnt++; end while (ready !== 1'b1 && cnt < 60);
      chk("relock_ready", 32'(ready), 1);
    end
    chk("relock_three", 32'(relock_count), 3);

    // Lock glitch in STABLE at count 5 (loss reaches the FSM as the count completes)
    pll_locked = 1'b0;
    cnt = 0;
    while (pll_rst !== 1'b1 && cnt < 10) begin step(); cnt++; end
    pll_locked = 1'b1;
    cnt = 0;
    while (!(ph == 2 && n_edge - t0 == 5) && cnt < 60) begin step(); cnt++; end
    chk("glitch_pre_sys_reset", 32'(sys_reset), 1);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    cnt = 0;
    do begin step(); cnt++; end while (ready !== 1'b1 && cnt < 60);
    chk("glitch_ready_lat", cnt, L + 3);
    chk("glitch_terr", 32'(timeout_err), 0);

    // Lock timeout: retry pulse and period with lock held low
    pll_locked = 1'b0;
    cnt = 0;
    while (pll_rst !== 1'b1 && cnt < 10) begin step(); cnt++; end
    cnt = 0;
    while (pll_rst === 1'b1 && cnt < 20) begin step(); cnt++; end
    cnt = 0;
    do begin step(); cnt++; end while (pll_rst !== 1'b1 && cnt < 100);
    chk("timeout_len", cnt, T);
    chk("timeout_terr", 32'(timeout_err), 1);
    cnt = 0;
    while (pll_rst === 1'b1 && cnt < 20) begin step(); cnt++; end
    chk("retry_pulse_len", cnt, P);
    cnt = 0;
    do begin step(); cnt++; end while (pll_rst !== 1'b1 && cnt < 100);
    chk("timeout_period", cnt + P, T + P);
    chk("timeout_terr_sticky", 32'(timeout_err), 1);

    // Lock arriving exactly on the timeout cycle
    rst = 1'b1; step(); rst = 1'b0;
    chk("clr_terr", 32'(timeout_err), 0);
    cnt = 0;
    while (pll_rst === 1'b1 && cnt < 20) begin step(); cnt++; end
    repeat (T - 3) step();
    pll_locked = 1'b1;
    repeat (6) step();
    chk("edge_lock_terr", 32'(timeout_err), 0);
    chk("edge_lock_pll_rst", 32'(pll_rst), 0);

    // Saturation: 260 lock losses in RUN
    for (int i = 0; i < 260; i++) begin
      cnt = 0;
      while (ready !== 1'b1 && cnt < 60) begin step(); cnt++; end
      repeat ($urandom_range(0, 3)) step();
      pll_locked = 1'b0;
      cnt = 0;
      while (pll_rst !== 1'b1 && cnt < 10) begin step(); cnt++; end
      pll_locked = 1'b1;
    end
    chk("relock_sat", 32'(relock_count), 255);

    // Reset mid-STABLE on the edge that would act on lock loss
    cnt = 0;
    while (!(ph == 2 && n_edge - t0 == 3) && cnt < 60) begin step(); cnt++; end
    pll_locked = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    chk("rst_stable_pll_rst",   32'(pll_rst), 1);
    chk("rst_stable_sys_reset", 32'(sys_reset), 1);
    chk("rst_stable_ready",     32'(ready), 0);
    chk("rst_stable_relock",    32'(relock_count), 0);
    chk("rst_stable_terr",      32'(timeout_err), 0);

    // Reset colliding with lock loss in RUN: no relock increment
    rst = 1'b0; pll_locked = 1'b1;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 60) begin step(); cnt++; end
    pll_locked = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    chk("rst_run_relock", 32'(relock_count), 0);
    chk("rst_run_ready",  32'(ready), 0);

    // Reset colliding with timeout: no error recorded
    rst = 1'b0;
    cnt = 0;
    while (pll_rst === 1'b1 && cnt < 20) begin step(); cnt++; end
    repeat (T - 1) step();
    rst = 1'b1;
    step();
    chk("rst_timeout_terr", 32'(timeout_err), 0);
    chk("rst_timeout_pll_rst", 32'(pll_rst), 1);

    // Random lock activity with occasional resets
    rst = 1'b0; pll_locked = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      if (pll_locked ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 9) == 0))
        pll_locked = ~pll_locked;
      step();
    end
    rst = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_ctrl.md
# pll_reset_ctrl

Reset and lock supervisor for the system PLL, clocked directly from the 50 MHz board reference clock. It drives the PLL's reset input with a timed power-on pulse and monitors the PLL `locked` output through a synchronizer. It releases the core's system reset only after lock has held for a programmable number of cycles. It re-sequences the PLL on lock loss or lock timeout and keeps a small status record for debug.

## Interface
Parameters:
- `PLL_RST_CYCLES`, default 50: number of `refclk` cycles the PLL reset is held (1 µs at 50 MHz). Must be ≥2.
- `LOCK_STABLE_CYCLES`, default 1024: number of consecutive synchronized-lock cycles required before core reset is released. Must be ≥2.
- `LOCK_TIMEOUT_CYCLES`, default 500000: maximum wait for lock after PLL reset release (10 ms). Must be ≥2.
- `CNT_W`, default 20: width of the shared cycle counter. Must hold `max(param)-1`.

Ports:
- `refclk`, in, 1: the single clock (board reference).
- `rst`, in, 1: reset, synchronous, active-high.
- `pll_locked`, in, 1: raw `locked` output of the PLL. It is asynchronous to `refclk`.
- `pll_rst`, out, 1: reset to the PLL, active-high, registered.
- `sys_reset`, out, 1: reset to the core clock domains, active-high, registered.
- `ready`, out, 1: high exactly while in RUN, registered.
- `relock_count`, out, 8: number of lock losses seen in RUN, saturating at 255.
- `timeout_err`, out, 1: sticky flag set on any lock timeout. Cleared only by `rst`.

## Operation
- `pll_locked` passes through a 2-FF synchronizer (`lk_s1`, `lk_s2`), both of which reset to 0. All decisions use `lk_s2`.
- There is a single counter `cnt` of width `CNT_W`, which is zeroed on every state entry.
- States:
  - **PLL_RST**: `pll_rst`=1, `sys_reset`=1, `ready`=0. `cnt` increments each cycle. When `cnt==PLL_RST_CYCLES-1`, go to WAIT_LOCK.
  - **WAIT_LOCK**: `pll_rst`=0, `sys_reset`=1.
    - If `lk_s2`=1, go to STABLE.
    - Otherwise, if `cnt==LOCK_TIMEOUT_CYCLES-1`, go to PLL_RST and set `timeout_err`.
    - Otherwise increment `cnt`.
  - **STABLE**: `pll_rst`=0, `sys_reset`=1.
    - If `lk_s2`=0, go to WAIT_LOCK; the timeout restarts from 0.
    - Otherwise, if `cnt==LOCK_STABLE_CYCLES-1`, go to RUN.
    - Otherwise increment `cnt`.
  - **RUN**: `pll_rst`=0, `sys_reset`=0, `ready`=1. If `lk_s2`=0, go to PLL_RST and increment `relock_count` (saturating).
- Outputs are registered and decoded from the next state, so each output changes on the same edge as the state transition.
- Reset (`rst`=1 at an edge) has these effects:
  - state goes to PLL_RST with `cnt`=0;
  - `pll_rst`=1, `sys_reset`=1, `ready`=0;
  - `relock_count`=0, `timeout_err`=0;
  - synchronizer cleared.
- `rst` asserted mid-sequence in any state aborts that sequence immediately, at that edge, with the same results. It also wins over a simultaneous lock loss or timeout: neither `relock_count` nor `timeout_err` is updated on that edge.
- Lock dropping in the same cycle that a STABLE count completes: `lk_s2`=0 takes priority, and the block goes to WAIT_LOCK.
- Lock asserting on the exact timeout cycle: `lk_s2`=1 takes priority, and the block goes to STABLE with no error.

## Timing
- Reset values: `pll_rst`=1, `sys_reset`=1, `ready`=0, `relock_count`=0, `timeout_err`=0.
- PLL reset pulse: `pll_rst` is high for exactly `PLL_RST_CYCLES` edges after the first edge with `rst`=0. It falls on edge `PLL_RST_CYCLES`, counting that first edge as edge 1.
- Lock-to-ready latency: let edge k be the first to sample `pll_locked`=1 into `lk_s1`.
  - STABLE is entered at edge k+2.
  - `ready` rises and `sys_reset` falls at edge k+2+`LOCK_STABLE_CYCLES`, provided lock holds throughout.
- Lock-loss latency: let edge k be the first to sample `pll_locked`=0 while in RUN. At edge k+2:
  - `sys_reset` rises, `ready` falls and `pll_rst` rises;
  - `relock_count` increments.
- Timeout: `pll_rst` rises again `LOCK_TIMEOUT_CYCLES` edges after it fell, if `lk_s2` stayed 0 throughout.
- No glitches: every output is a flop.

## Test plan
All scenarios use `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32.
- **Power-on:** hold `rst` for 3 cycles, then release. Raise `pll_locked` 10 cycles later. Expect:
  - `pll_rst` high for exactly 4 edges after release;
  - `ready`=1 and `sys_reset`=0 exactly 10 edges after the first edge sampling locked=1;
  - `relock_count`=0.
- **Lock glitch during STABLE:** drop `pll_locked` for 1 cycle at count 5. Expect:
  - no `ready`;
  - the stable count restarts;
  - `ready` asserts 8 cycles after the re-entry to STABLE;
  - `timeout_err`=0.
- **Lock timeout:** keep `pll_locked`=0. Expect:
  - `pll_rst` re-asserts 32 edges after it fell, for 4 cycles;
  - `timeout_err`=1 and stays 1;
  - the cycle repeats every 36 cycles.
- **Lock loss in RUN:** drop `pll_locked` 3 times, re-locking each time. Expect:
  - `sys_reset`/`pll_rst` rise 2 edges after each drop;
  - `relock_count`=3 after the third loss.
- **Saturation:** force 260 lock losses in RUN. Expect `relock_count`=255.
- **Reset mid-STABLE with simultaneous lock loss:** assert `rst` on the edge where `lk_s2` falls. Expect:
  - PLL_RST entered;
  - `relock_count` and `timeout_err` = 0;
  - `pll_rst`=1, `sys_reset`=1, `ready`=0.
